// File: rtl/ball_pkg.sv
// Shared types and defaults for the multi-ball motion engine.
// Positions are signed fixed point; speeds are 11-bit signed fixed point.
package ball_pkg;

  localparam int FRAC_BITS_DEF = 6;
  localparam int X_MAX_DEF     = 639;
  localparam int Y_MAX_DEF     = 479;

  // Slot storage is wide enough for any FRAC_BITS up to FRAC_BITS_MAX
  localparam int FRAC_BITS_MAX = 16;
  localparam int POS_W         = 12 + FRAC_BITS_MAX;
  localparam int SPD_W         = 11;

  // ST_IDLE | waiting for frame / accepting spawn+kill
  // ST_UPDATE | stepping slot r_idx
  // ST_DONE | frame finished, frameDone follows
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [SPD_W-1:0] vx;
    logic [SPD_W-1:0] vy;
    logic             active;
  } ball_t;

  function automatic logic [SPD_W-1:0] sat_speed(input logic signed [SPD_W+1:0] v,
                                                 input int vmax);
    if (v > vmax)
      return SPD_W'(vmax);
    else if (v < -vmax)
      return SPD_W'(-vmax);
    else
      return v[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/ball_step.sv
// One-slot kinematics: move by old speed, clamp to the playfield, reflect
// and saturate speeds, add gravity only on a free Y step.
module ball_step
  import ball_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int GRAVITY   = 1,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int Y_MAX     = Y_MAX_DEF,
  parameter int V_MAX     = 1023
) (
  input  ball_t i_ball,
  output ball_t o_ball,
  output logic  o_bounce
);

  localparam int EW = POS_W + 1;
  localparam int VW = SPD_W + 2;
  localparam logic signed [EW-1:0] X_LIM = EW'(longint'(X_MAX) << FRAC_BITS);
  localparam logic signed [EW-1:0] Y_LIM = EW'(longint'(Y_MAX) << FRAC_BITS);

  logic signed [EW-1:0] w_nx, w_ny;
  logic signed [VW-1:0] w_vx, w_vy, w_vx_abs, w_vy_abs, w_vy_grav;
  logic                 w_bx, w_by;

  always_comb begin
    w_vx      = $signed({{2{i_ball.vx[SPD_W-1]}}, i_ball.vx});
    w_vy      = $signed({{2{i_ball.vy[SPD_W-1]}}, i_ball.vy});
    w_vx_abs  = w_vx[VW-1] ? -w_vx : w_vx;
    w_vy_abs  = w_vy[VW-1] ? -w_vy : w_vy;
    w_vy_grav = w_vy + VW'(GRAVITY);
    w_nx      = $signed({i_ball.x[POS_W-1], i_ball.x}) +
                $signed({{(EW-SPD_W){i_ball.vx[SPD_W-1]}}, i_ball.vx});
    w_ny      = $signed({i_ball.y[POS_W-1], i_ball.y}) +
                $signed({{(EW-SPD_W){i_ball.vy[SPD_W-1]}}, i_ball.vy});

    o_ball = i_ball;
    w_bx   = 1'b0;
    w_by   = 1'b0;

    if (i_ball.active) begin
      if (w_nx[EW-1]) begin
        o_ball.x  = '0;
        o_ball.vx = sat_speed(w_vx_abs, V_MAX);
        w_bx      = 1'b1;
      end else if (w_nx > X_LIM) begin
        o_ball.x  = X_LIM[POS_W-1:0];
        o_ball.vx = sat_speed(-w_vx_abs, V_MAX);
        w_bx      = 1'b1;
      end else begin
        o_ball.x  = w_nx[POS_W-1:0];
        o_ball.vx = sat_speed(w_vx, V_MAX);
      end

      // a Y bounce reflects the speed without the gravity increment
      if (w_ny[EW-1]) begin
        o_ball.y  = '0;
        o_ball.vy = sat_speed(w_vy_abs, V_MAX);
        w_by      = 1'b1;
      end else if (w_ny > Y_LIM) begin
        o_ball.y  = Y_LIM[POS_W-1:0];
        o_ball.vy = sat_speed(-w_vy_abs, V_MAX);
        w_by      = 1'b1;
      end else begin
        o_ball.y  = w_ny[POS_W-1:0];
        o_ball.vy = sat_speed(w_vy_grav, V_MAX);
      end
    end

    o_bounce = w_bx | w_by;
  end

endmodule

// File: rtl/multi_ball_move.sv
// Multi-slot ball mover: one slot stepped per cycle after each startOfFrame,
// with spawn/kill handshakes accepted only while idle.
module multi_ball_move
  import ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int GRAVITY   = 1,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int Y_MAX     = Y_MAX_DEF,
  parameter int V_MAX     = 1023,
  localparam int IDX_W    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        spawnValid,
  output logic                        spawnReady,
  input  logic [10:0]                 spawnX,
  input  logic [10:0]                 spawnY,
  input  logic [10:0]                 spawnXspeed,
  input  logic [10:0]                 spawnYspeed,
  input  logic                        killValid,
  output logic                        killReady,
  input  logic [IDX_W-1:0]            killIdx,
  output logic [NUM_BALLS-1:0][10:0]  topLeftX,
  output logic [NUM_BALLS-1:0][10:0]  topLeftY,
  output logic [NUM_BALLS-1:0]        active,
  output logic                        busy,
  output logic                        frameDone,
  output logic                        frameOverrun,
  output logic [NUM_BALLS-1:0]        bounceEvent
);

  fsm_state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  ball_t                r_slot [NUM_BALLS];
  logic [NUM_BALLS-1:0] r_bounce;
  logic                 r_frame_done, r_overrun;

  ball_t                w_step_out, w_spawn_ball;
  logic                 w_step_bounce;
  logic                 w_idle, w_free_any, w_spawn_go, w_kill_go;
  logic [IDX_W-1:0]     w_free_idx;

  ball_step #(
    .FRAC_BITS (FRAC_BITS),
    .GRAVITY   (GRAVITY),
    .X_MAX     (X_MAX),
    .Y_MAX     (Y_MAX),
    .V_MAX     (V_MAX)
  ) u_step (
    .i_ball   (r_slot[r_idx]),
    .o_ball   (w_step_out),
    .o_bounce (w_step_bounce)
  );

  // lowest-index free slot; scanning downward leaves the smallest index last
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (!r_slot[i].active) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    busy       = !w_idle;
    killReady  = w_idle && !startOfFrame;
    spawnReady = killReady && w_free_any;
    w_spawn_go = spawnValid && spawnReady;
    w_kill_go  = killValid && killReady && (int'(killIdx) < NUM_BALLS);

    w_spawn_ball        = '0;
    w_spawn_ball.x      = {{(POS_W-11){1'b0}}, spawnX} << FRAC_BITS;
    w_spawn_ball.y      = {{(POS_W-11){1'b0}}, spawnY} << FRAC_BITS;
    w_spawn_ball.vx     = spawnXspeed;
    w_spawn_ball.vy     = spawnYspeed;
    w_spawn_ball.active = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (startOfFrame) begin
          w_state_nxt = ST_UPDATE;
          w_idx_nxt   = '0;
        end
      end
      ST_UPDATE: begin
        if (r_idx == IDX_W'(NUM_BALLS - 1))
          w_state_nxt = ST_DONE;
        else
          w_idx_nxt = r_idx + 1'b1;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_BALLS; i++) r_slot[i] <= '0;
      r_bounce     <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_bounce     <= '0;
      r_frame_done <= (r_state == ST_DONE);
      r_overrun    <= startOfFrame && !w_idle;
      if (r_state == ST_UPDATE) begin
        r_slot[r_idx]   <= w_step_out;
        r_bounce[r_idx] <= w_step_bounce;
      end
      // kill first so a spawn into the same (already free) slot wins
      if (w_kill_go) r_slot[killIdx].active <= 1'b0;
      if (w_spawn_go) r_slot[w_free_idx] <= w_spawn_ball;
    end
  end

  for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_out
    assign topLeftX[gi] = r_slot[gi].x[FRAC_BITS +: 11];
    assign topLeftY[gi] = r_slot[gi].y[FRAC_BITS +: 11];
    assign active[gi]   = r_slot[gi].active;
  end

  assign bounceEvent  = r_bounce;
  assign frameDone    = r_frame_done;
  assign frameOverrun = r_overrun;

endmodule

// File: tb/tb_multi_ball_move.sv
// Directed bench for multi_ball_move with hand-computed expectations.
module tb_multi_ball_move;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic              spawnValid = 1'b0;
  logic              killValid = 1'b0;
  logic [10:0]       spawnX = '0, spawnY = '0, spawnXspeed = '0, spawnYspeed = '0;
  logic [1:0]        killIdx = '0;
  logic              spawnReady, killReady, busy, frameDone, frameOverrun;
  logic [N-1:0][10:0] topLeftX, topLeftY;
  logic [N-1:0]      active, bounceEvent;

  int checks = 0;
  int errors = 0;
  int frame_cycles;
  logic [N-1:0] frame_bounce;

  always #5 clk = ~clk;

  multi_ball_move #(.NUM_BALLS(N)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .spawnValid   (spawnValid),
    .spawnReady   (spawnReady),
    .spawnX       (spawnX),
    .spawnY       (spawnY),
    .spawnXspeed  (spawnXspeed),
    .spawnYspeed  (spawnYspeed),
    .killValid    (killValid),
    .killReady    (killReady),
    .killIdx      (killIdx),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .active       (active),
    .busy         (busy),
    .frameDone    (frameDone),
    .frameOverrun (frameOverrun),
    .bounceEvent  (bounceEvent)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one frame: pulse startOfFrame, then wait (bounded) for frameDone
  task automatic run_frame();
    int cnt;
    cnt = 0;
    frame_bounce = '0;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL frame_busy got %b exp 1", busy);
    end
    while (cnt < 20) begin
      tick();
      cnt++;
      frame_bounce |= bounceEvent;
      if (frameDone === 1'b1) break;
    end
    frame_cycles = cnt;
    checks++;
    if (frame_cycles != 5) begin
      errors++; $display("FAIL frame_latency got %0d exp 5", frame_cycles);
    end
  endtask

  task automatic do_spawn(input int x, input int y, input int vx, input int vy);
    spawnX = 11'(x); spawnY = 11'(y); spawnXspeed = 11'(vx); spawnYspeed = 11'(vy);
    spawnValid = 1'b1;
    checks++;
    if (spawnReady !== 1'b1) begin
      errors++; $display("FAIL spawn_ready got %b exp 1", spawnReady);
    end
    tick();
    spawnValid = 1'b0;
  endtask

  task automatic do_kill(input int idx);
    killIdx = 2'(idx);
    killValid = 1'b1;
    checks++;
    if (killReady !== 1'b1) begin
      errors++; $display("FAIL kill_ready got %b exp 1", killReady);
    end
    tick();
    killValid = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) tick();
    resetN = 1'b1;
    tick();
    checks++; if (topLeftX !== '0) begin errors++; $display("FAIL rst_x got %h exp 0", topLeftX); end
    checks++; if (topLeftY !== '0) begin errors++; $display("FAIL rst_y got %h exp 0", topLeftY); end
    checks++; if (active !== 4'b0000) begin errors++; $display("FAIL rst_active got %b exp 0000", active); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frameDone); end
    checks++; if (frameOverrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", frameOverrun); end
    checks++; if (bounceEvent !== 4'b0000) begin errors++; $display("FAIL rst_bounce got %b exp 0000", bounceEvent); end
    checks++; if (spawnReady !== 1'b1) begin errors++; $display("FAIL rst_spawn_ready got %b exp 1", spawnReady); end
    checks++; if (killReady !== 1'b1) begin errors++; $display("FAIL rst_kill_ready got %b exp 1", killReady); end
    startOfFrame = 1'b1;
    #1;
    checks++; if (spawnReady !== 1'b0) begin errors++; $display("FAIL sof_spawn_ready got %b exp 0", spawnReady); end
    checks++; if (killReady !== 1'b0) begin errors++; $display("FAIL sof_kill_ready got %b exp 0", killReady); end
    startOfFrame = 1'b0;
    tick();
    run_frame();
    checks++; if (topLeftX !== '0 || topLeftY !== '0 || active !== 4'b0000) begin
      errors++; $display("FAIL empty_frame got x=%h y=%h a=%b exp 0", topLeftX, topLeftY, active);
    end
    checks++; if (frame_bounce !== 4'b0000) begin errors++; $display("FAIL empty_bounce got %b exp 0000", frame_bounce); end
  endtask

  task automatic test_free_flight();
    do_spawn(100, 50, 64, 0);
    checks++; if (active !== 4'b0001) begin errors++; $display("FAIL ff_active got %b exp 0001", active); end
    checks++; if (topLeftX[0] !== 11'd100 || topLeftY[0] !== 11'd50) begin
      errors++; $display("FAIL ff_spawn_pos got %0d,%0d exp 100,50", topLeftX[0], topLeftY[0]);
    end
    // Y gains 0+1+..+(n-1) sub-pixels after n frames: 55 at n=11, 66 at n=12
    for (int f = 1; f <= 12; f++) begin
      run_frame();
      checks++; if (topLeftX[0] !== 11'(100 + f)) begin
        errors++; $display("FAIL ff_x frame %0d got %0d exp %0d", f, topLeftX[0], 100 + f);
      end
      checks++; if (topLeftY[0] !== ((f == 12) ? 11'd51 : 11'd50)) begin
        errors++; $display("FAIL ff_y frame %0d got %0d exp %0d", f, topLeftY[0], (f == 12) ? 51 : 50);
      end
      checks++; if (frame_bounce !== 4'b0000) begin
        errors++; $display("FAIL ff_bounce frame %0d got %b exp 0000", f, frame_bounce);
      end
    end
    do_kill(0);
    checks++; if (active !== 4'b0000) begin errors++; $display("FAIL ff_kill got %b exp 0000", active); end
  endtask

  task automatic test_walls();
    do_spawn(639, 479, 64, 10);
    do_spawn(0, 0, -64, -5);
    checks++; if (active !== 4'b0011) begin errors++; $display("FAIL wall_active got %b exp 0011", active); end
    run_frame();
    checks++; if (topLeftX[0] !== 11'd639 || topLeftY[0] !== 11'd479) begin
      errors++; $display("FAIL wall_far_pos got %0d,%0d exp 639,479", topLeftX[0], topLeftY[0]);
    end
    checks++; if (topLeftX[1] !== 11'd0 || topLeftY[1] !== 11'd0) begin
      errors++; $display("FAIL wall_near_pos got %0d,%0d exp 0,0", topLeftX[1], topLeftY[1]);
    end
    checks++; if (frame_bounce !== 4'b0011) begin errors++; $display("FAIL wall_bounce got %b exp 0011", frame_bounce); end
    run_frame();
    checks++; if (topLeftX[0] !== 11'd638 || topLeftY[0] !== 11'd478) begin
      errors++; $display("FAIL wall_far_f2 got %0d,%0d exp 638,478", topLeftX[0], topLeftY[0]);
    end
    checks++; if (topLeftX[1] !== 11'd1 || topLeftY[1] !== 11'd0) begin
      errors++; $display("FAIL wall_near_f2 got %0d,%0d exp 1,0", topLeftX[1], topLeftY[1]);
    end
    checks++; if (frame_bounce !== 4'b0000) begin errors++; $display("FAIL wall_bounce_f2 got %b exp 0000", frame_bounce); end
    run_frame();
    checks++; if (topLeftX[0] !== 11'd637 || topLeftY[0] !== 11'd478) begin
      errors++; $display("FAIL wall_far_f3 got %0d,%0d exp 637,478", topLeftX[0], topLeftY[0]);
    end
    checks++; if (topLeftX[1] !== 11'd2) begin
      errors++; $display("FAIL wall_near_f3 got %0d exp 2", topLeftX[1]);
    end
    do_kill(0);
    do_kill(1);
  endtask

  task automatic test_full_kill();
    for (int i = 0; i < 4; i++) do_spawn(10 + 10 * i, 20 + i, 0, 0);
    checks++; if (active !== 4'b1111) begin errors++; $display("FAIL full_active got %b exp 1111", active); end
    checks++; if (spawnReady !== 1'b0) begin errors++; $display("FAIL full_spawn_ready got %b exp 0", spawnReady); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (topLeftX[i] !== 11'(10 + 10 * i) || topLeftY[i] !== 11'(20 + i)) begin
        errors++; $display("FAIL full_pos slot %0d got %0d,%0d exp %0d,%0d", i, topLeftX[i], topLeftY[i], 10 + 10 * i, 20 + i);
      end
    end
    do_kill(2);
    checks++; if (active !== 4'b1011) begin errors++; $display("FAIL kill2_active got %b exp 1011", active); end
    do_spawn(300, 200, 0, 0);
    checks++; if (active !== 4'b1111 || topLeftX[2] !== 11'd300 || topLeftY[2] !== 11'd200) begin
      errors++; $display("FAIL respawn2 got a=%b %0d,%0d exp 1111 300,200", active, topLeftX[2], topLeftY[2]);
    end
    do_kill(1);
    checks++; if (active !== 4'b1101) begin errors++; $display("FAIL kill1_active got %b exp 1101", active); end
    // simultaneous: spawn takes pre-kill free slot 1, kill clears slot 3
    spawnX = 11'd400; spawnY = 11'd100; spawnXspeed = '0; spawnYspeed = '0;
    spawnValid = 1'b1; killValid = 1'b1; killIdx = 2'd3;
    tick();
    spawnValid = 1'b0; killValid = 1'b0;
    checks++; if (active !== 4'b0111) begin errors++; $display("FAIL both_active got %b exp 0111", active); end
    checks++; if (topLeftX[1] !== 11'd400 || topLeftY[1] !== 11'd100) begin
      errors++; $display("FAIL both_pos got %0d,%0d exp 400,100", topLeftX[1], topLeftY[1]);
    end
  endtask

  task automatic test_overrun_reset();
    int cnt;
    int extra_done;
    int extra_busy;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checks++; if (frameOverrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %b exp 1", frameOverrun); end
    tick();
    checks++; if (frameOverrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", frameOverrun); end
    cnt = 3;
    while (cnt < 20 && frameDone !== 1'b1) begin
      tick();
      cnt++;
    end
    checks++; if (cnt != 5) begin errors++; $display("FAIL overrun_latency got %0d exp 5", cnt); end
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frameDone === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    checks++; if (extra_done != 0 || extra_busy != 0) begin
      errors++; $display("FAIL overrun_restart got done=%0d busy=%0d exp 0,0", extra_done, extra_busy);
    end
    checks++; if (topLeftX[0] !== 11'd10 || active !== 4'b0111) begin
      errors++; $display("FAIL overrun_state got x=%0d a=%b exp 10 0111", topLeftX[0], active);
    end
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    resetN = 1'b0;
    #1;
    checks++; if (active !== 4'b0000 || topLeftX !== '0 || topLeftY !== '0) begin
      errors++; $display("FAIL midreset_slots got a=%b x=%h y=%h exp 0", active, topLeftX, topLeftY);
    end
    checks++; if (busy !== 1'b0 || spawnReady !== 1'b1 || killReady !== 1'b1) begin
      errors++; $display("FAIL midreset_ctrl got busy=%b sr=%b kr=%b exp 0,1,1", busy, spawnReady, killReady);
    end
    #3;
    resetN = 1'b1;
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frameDone === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    checks++; if (extra_done != 0 || extra_busy != 0) begin
      errors++; $display("FAIL midreset_abandon got done=%0d busy=%0d exp 0,0", extra_done, extra_busy);
    end
  endtask

  initial begin
    test_reset();
    test_free_flight();
    test_walls();
    test_full_kill();
    test_overrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
